// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave to register-map bus bridge: one-entry AW/W/AR buffers,
// round-robin read/write arbitration, single outstanding access with timeout.
module axi4lite_reg_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    output logic                    bus_req_stall_wr,
    output logic                    bus_req_stall_rd,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data,
    input  logic                    bus_err
);

    // state   | meaning
    // IDLE    | waiting for an eligible write (AW+W) or read (AR)
    // WR_REQ  | write presented on register bus, waiting bus_ready/timeout
    // RD_REQ  | read presented on register bus, waiting bus_ready/timeout
    // WR_RESP | B response valid, waiting s_bready
    // RD_RESP | R response valid, waiting s_rready
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t state, state_nxt;

    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  last_rd;
    logic [CNT_W-1:0]      to_cnt;
    logic                  aw_hs, w_hs, ar_hs, wr_elig, rd_elig;
    logic                  in_req, timeout, wr_done, rd_done;

    assign s_awready = !aw_full;
    assign s_wready  = !w_full;
    assign s_arready = !ar_full;

    assign aw_hs = s_awvalid && !aw_full;
    assign w_hs  = s_wvalid && !w_full;
    assign ar_hs = s_arvalid && !ar_full;

    // Count same-cycle captures so an accept in cycle N yields bus_req in N+1
    assign wr_elig = (aw_full || aw_hs) && (w_full || w_hs);
    assign rd_elig = ar_full || ar_hs;

    assign in_req  = (state == WR_REQ) || (state == RD_REQ);
    assign timeout = TO_EN && in_req && !bus_ready && (to_cnt == TO_LAST);
    assign wr_done = (state == WR_REQ) && (bus_ready || timeout);
    assign rd_done = (state == RD_REQ) && (bus_ready || timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_elig && (!rd_elig || last_rd)) state_nxt = WR_REQ;
                else if (rd_elig)                      state_nxt = RD_REQ;
            end
            WR_REQ:  if (wr_done) state_nxt = WR_RESP;
            RD_REQ:  if (rd_done) state_nxt = RD_RESP;
            WR_RESP: if (s_bready) state_nxt = IDLE;
            RD_RESP: if (s_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end else if (wr_done) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end else if (wr_done) begin
                w_full <= 1'b0;
            end
            if (ar_hs) begin
                ar_full   <= 1'b1;
                ar_addr_q <= s_araddr;
            end else if (rd_done) begin
                ar_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_rd <= 1'b1;
            to_cnt  <= '0;
            s_bresp <= 2'b00;
            s_rresp <= 2'b00;
            s_rdata <= '0;
        end else begin
            if (state == IDLE && state_nxt == WR_REQ) last_rd <= 1'b0;
            if (state == IDLE && state_nxt == RD_REQ) last_rd <= 1'b1;
            if (TO_EN && in_req && !bus_ready) to_cnt <= to_cnt + 1'b1;
            else                               to_cnt <= '0;
            // Completion beats timeout when both land in the same cycle
            if (wr_done) s_bresp <= (!bus_ready || bus_err) ? 2'b10 : 2'b00;
            if (rd_done) begin
                s_rresp <= (!bus_ready || bus_err) ? 2'b10 : 2'b00;
                s_rdata <= bus_ready ? bus_rd_data : '0;
            end
        end
    end

    always_comb begin
        bus_req          = in_req;
        bus_req_is_wr    = (state == WR_REQ);
        bus_addr         = '0;
        bus_wr_data      = '0;
        bus_wr_biten     = '0;
        s_bvalid         = (state == WR_RESP);
        s_rvalid         = (state == RD_RESP);
        bus_req_stall_wr = (state == WR_RESP) && !s_bready;
        bus_req_stall_rd = (state == RD_RESP) && !s_rready;
        if (state == WR_REQ) begin
            bus_addr    = aw_addr_q;
            bus_wr_data = w_data_q;
            for (int i = 0; i < STRB_W; i++) begin
                bus_wr_biten[8*i +: 8] = {8{w_strb_q[i]}};
            end
        end else if (state == RD_REQ) begin
            bus_addr = ar_addr_q;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed self-checking bench for axi4lite_reg_bridge (TIMEOUT_CYCLES = 4).
module tb_axi4lite_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic        bus_req, bus_req_is_wr;
    logic [31:0] bus_addr, bus_wr_data, bus_wr_biten, bus_rd_data;
    logic        bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err;

    int checks = 0;
    int failures = 0;

    axi4lite_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_rd_data(bus_rd_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timer expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        bus_ready = 0; bus_rd_data = '0; bus_err = 0;
        repeat (2) tick();
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
        checks++; if (bus_req_is_wr !== 1'b0) begin failures++; $display("FAIL rst_is_wr got=%0h exp=0", bus_req_is_wr); end
        checks++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin failures++; $display("FAIL rst_valids got=%0h%0h exp=00", s_bvalid, s_rvalid); end
        checks++; if (bus_req_stall_wr !== 1'b0 || bus_req_stall_rd !== 1'b0) begin failures++; $display("FAIL rst_stalls got=%0h%0h exp=00", bus_req_stall_wr, bus_req_stall_rd); end
        checks++; if (bus_addr !== 32'h0 || bus_wr_data !== 32'h0 || bus_wr_biten !== 32'h0) begin failures++; $display("FAIL rst_bus_fields addr=%h data=%h biten=%h exp=0", bus_addr, bus_wr_data, bus_wr_biten); end
        checks++; if (s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin failures++; $display("FAIL rst_resp rdata=%h bresp=%0h rresp=%0h exp=0", s_rdata, s_bresp, s_rresp); end
        checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin failures++; $display("FAIL rst_readies got=%0h%0h%0h exp=111", s_awready, s_wready, s_arready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write;
        s_awaddr = 32'h10; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'b0101; s_wvalid = 1;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL wr_early_req got=%0h exp=0", bus_req); end
        tick();
        s_awvalid = 0; s_wvalid = 0;
        checks++; if (bus_req !== 1'b1 || bus_req_is_wr !== 1'b1) begin failures++; $display("FAIL wr_req got=%0h/%0h exp=1/1", bus_req, bus_req_is_wr); end
        checks++; if (bus_addr !== 32'h10) begin failures++; $display("FAIL wr_addr got=%h exp=00000010", bus_addr); end
        checks++; if (bus_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data got=%h exp=deadbeef", bus_wr_data); end
        checks++; if (bus_wr_biten !== 32'h00FF00FF) begin failures++; $display("FAIL wr_biten got=%h exp=00ff00ff", bus_wr_biten); end
        checks++; if (s_awready !== 1'b0 || s_wready !== 1'b0) begin failures++; $display("FAIL wr_buf_full got=%0h%0h exp=00", s_awready, s_wready); end
        bus_ready = 1;
        tick();
        bus_ready = 0;
        checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%0h/%0h exp=1/0", s_bvalid, s_bresp); end
        checks++; if (bus_req !== 1'b0 || bus_req_stall_wr !== 1'b1) begin failures++; $display("FAIL wr_resp_state req=%0h stall=%0h exp=0/1", bus_req, bus_req_stall_wr); end
        checks++; if (s_awready !== 1'b1) begin failures++; $display("FAIL wr_buf_freed got=%0h exp=1", s_awready); end
        s_bready = 1;
        tick();
        s_bready = 0;
        checks++; if (s_bvalid !== 1'b0 || bus_req_stall_wr !== 1'b0) begin failures++; $display("FAIL wr_bdone got=%0h/%0h exp=0/0", s_bvalid, bus_req_stall_wr); end
    endtask

    task automatic test_single_read;
        s_araddr = 32'h24; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        checks++; if (bus_req !== 1'b1 || bus_req_is_wr !== 1'b0 || bus_addr !== 32'h24) begin failures++; $display("FAIL rd_req req=%0h wr=%0h addr=%h exp=1/0/24", bus_req, bus_req_is_wr, bus_addr); end
        checks++; if (bus_wr_data !== 32'h0 || bus_wr_biten !== 32'h0) begin failures++; $display("FAIL rd_zero_wr data=%h biten=%h exp=0", bus_wr_data, bus_wr_biten); end
        bus_ready = 1; bus_rd_data = 32'hCAFE0001;
        tick();
        bus_ready = 0; bus_rd_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE0001 || s_rresp !== 2'b00) begin failures++; $display("FAIL rd_hold%0d valid=%0h data=%h resp=%0h exp=1/cafe0001/0", i, s_rvalid, s_rdata, s_rresp); end
            checks++; if (bus_req_stall_rd !== 1'b1) begin failures++; $display("FAIL rd_stall%0d got=%0h exp=1", i, bus_req_stall_rd); end
            tick();
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        checks++; if (s_rvalid !== 1'b0 || bus_req_stall_rd !== 1'b0) begin failures++; $display("FAIL rd_done got=%0h/%0h exp=0/0", s_rvalid, bus_req_stall_rd); end
    endtask

    task automatic test_w_before_aw;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_req !== 1'b0 || s_wready !== 1'b0) begin failures++; $display("FAIL wfirst_wait%0d req=%0h wready=%0h exp=0/0", i, bus_req, s_wready); end
            tick();
        end
        s_awaddr = 32'h30; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h30 || bus_wr_biten !== 32'hFFFFFFFF) begin failures++; $display("FAIL wfirst_req req=%0h addr=%h biten=%h exp=1/30/ffffffff", bus_req, bus_addr, bus_wr_biten); end
        bus_ready = 1; bus_err = 1;
        tick();
        bus_ready = 0; bus_err = 0;
        checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin failures++; $display("FAIL wfirst_slverr got=%0h/%0h exp=1/2", s_bvalid, s_bresp); end
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

    task automatic test_arbitration;
        rst = 0;
        tick();
        rst = 1;
        tick();
        s_awaddr = 32'h40; s_wdata = 32'h11; s_wstrb = 4'hF; s_araddr = 32'h44;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        checks++; if (bus_req_is_wr !== 1'b1 || bus_addr !== 32'h40) begin failures++; $display("FAIL arb_first_write wr=%0h addr=%h exp=1/40", bus_req_is_wr, bus_addr); end
        checks++; if (s_arready !== 1'b0) begin failures++; $display("FAIL arb_ar_captured got=%0h exp=0", s_arready); end
        bus_ready = 1;
        tick();
        bus_ready = 0;
        checks++; if (s_bvalid !== 1'b1 || s_rvalid !== 1'b0) begin failures++; $display("FAIL arb_one_valid b=%0h r=%0h exp=1/0", s_bvalid, s_rvalid); end
        // new write buffered during WR_RESP sets up a tie with the pending read
        s_awaddr = 32'h48; s_wdata = 32'h22; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_bready = 0;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL arb_idle_gap got=%0h exp=0", bus_req); end
        tick();
        checks++; if (bus_req !== 1'b1 || bus_req_is_wr !== 1'b0 || bus_addr !== 32'h44) begin failures++; $display("FAIL arb_second_read req=%0h wr=%0h addr=%h exp=1/0/44", bus_req, bus_req_is_wr, bus_addr); end
        bus_ready = 1; bus_rd_data = 32'h55;
        tick();
        bus_ready = 0; bus_rd_data = 32'h0;
        checks++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h55 || s_bvalid !== 1'b0) begin failures++; $display("FAIL arb_rdata r=%0h data=%h b=%0h exp=1/55/0", s_rvalid, s_rdata, s_bvalid); end
        s_rready = 1;
        tick();
        s_rready = 0;
        tick();
        checks++; if (bus_req_is_wr !== 1'b1 || bus_addr !== 32'h48 || bus_wr_data !== 32'h22) begin failures++; $display("FAIL arb_third_write wr=%0h addr=%h data=%h exp=1/48/22", bus_req_is_wr, bus_addr, bus_wr_data); end
        bus_ready = 1;
        tick();
        bus_ready = 0;
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

    task automatic test_timeout;
        s_awaddr = 32'h50; s_wdata = 32'h99; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL to_wr_req%0d got=%0h exp=1", i, bus_req); end
            tick();
        end
        checks++; if (bus_req !== 1'b0 || s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin failures++; $display("FAIL to_wr_resp req=%0h b=%0h resp=%0h exp=0/1/2", bus_req, s_bvalid, s_bresp); end
        checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1) begin failures++; $display("FAIL to_wr_freed got=%0h%0h exp=11", s_awready, s_wready); end
        s_bready = 1;
        tick();
        s_bready = 0;
        s_araddr = 32'h54; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        repeat (4) tick();
        checks++; if (s_rvalid !== 1'b1 || s_rresp !== 2'b10 || s_rdata !== 32'h0) begin failures++; $display("FAIL to_rd_resp r=%0h resp=%0h data=%h exp=1/2/0", s_rvalid, s_rresp, s_rdata); end
        s_rready = 1;
        tick();
        s_rready = 0;
        s_awaddr = 32'h58; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        repeat (3) tick();
        bus_ready = 1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL to_edge_req got=%0h exp=1", bus_req); end
        tick();
        bus_ready = 0;
        checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin failures++; $display("FAIL to_edge_okay b=%0h resp=%0h exp=1/0", s_bvalid, s_bresp); end
        s_bready = 1;
        tick();
        s_bready = 0;
        s_araddr = 32'h5C; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        bus_ready = 1; bus_rd_data = 32'hA5A5A5A5;
        tick();
        bus_ready = 0; bus_rd_data = 32'h0;
        checks++; if (s_rvalid !== 1'b1 || s_rresp !== 2'b00 || s_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL to_recover r=%0h resp=%0h data=%h exp=1/0/a5a5a5a5", s_rvalid, s_rresp, s_rdata); end
        s_rready = 1;
        tick();
        s_rready = 0;
    endtask

    task automatic test_reset_mid;
        s_awaddr = 32'h60; s_wdata = 32'h77; s_wstrb = 4'h3; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rmid_req got=%0h exp=1", bus_req); end
        #2 rst = 0;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_req_is_wr !== 1'b0 || bus_addr !== 32'h0 || bus_wr_data !== 32'h0 || bus_wr_biten !== 32'h0) begin failures++; $display("FAIL rmid_bus req=%0h wr=%0h addr=%h data=%h biten=%h exp=0", bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten); end
        checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_bvalid !== 1'b0) begin failures++; $display("FAIL rmid_axi aw=%0h w=%0h b=%0h exp=1/1/0", s_awready, s_wready, s_bvalid); end
        tick();
        rst = 1;
        s_bready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (s_bvalid !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL rmid_after%0d b=%0h req=%0h exp=0/0", i, s_bvalid, bus_req); end
        end
        s_bready = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_w_before_aw();
        test_arbitration();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_bridge.md
# axi4lite_reg_bridge

AXI4-Lite slave front-end that converts AXI read and write transactions into single-access requests on the register-map bus (Bus2Reg_intf BUS-side signals). It sits directly upstream of the generated register map. It buffers the AW and W channels independently, arbitrates reads against writes, runs one register access at a time, and returns responses on B/R. A configurable timeout protects the AXI master from a register map that never returns bus_ready.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data / register width; must be 32 or 64.
- ADDR_WIDTH, 32, AXI and register address width.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for bus_ready; 0 disables the timeout.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- s_awaddr in ADDR_WIDTH, s_awvalid in 1, s_awready out 1: AXI write address channel.
- s_wdata in DATA_WIDTH, s_wstrb in DATA_WIDTH/8, s_wvalid in 1, s_wready out 1: AXI write data channel.
- s_bresp out 2, s_bvalid out 1, s_bready in 1: AXI write response channel.
- s_araddr in ADDR_WIDTH, s_arvalid in 1, s_arready out 1: AXI read address channel.
- s_rdata out DATA_WIDTH, s_rresp out 2, s_rvalid out 1, s_rready in 1: AXI read data channel.
- bus_req out 1, bus_req_is_wr out 1, bus_addr out ADDR_WIDTH, bus_wr_data out DATA_WIDTH, bus_wr_biten out DATA_WIDTH: register request.
- bus_req_stall_wr out 1, bus_req_stall_rd out 1: response-backpressure indicators.
- bus_ready in 1, bus_rd_data in DATA_WIDTH, bus_err in 1: register completion.
- All bus_* ports map 1:1 onto the BUS modport of Bus2Reg_intf.

## Operation
- AW buffer (1 entry) and W buffer (1 entry) fill independently. s_awready = !aw_full; s_wready = !w_full. An entry is captured on valid&&ready.
- AR buffer (1 entry): s_arready = !ar_full.
- A write is eligible when aw_full && w_full. A read is eligible when ar_full.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
  - In IDLE, if both a write and a read are eligible, arbitration is round-robin: the type not served last wins. Reset value of last-served is "read", so the first tie goes to the write.
  - IDLE -> WR_REQ or RD_REQ.
  - WR_REQ/RD_REQ -> WR_RESP/RD_RESP on bus_ready or on timeout.
  - WR_RESP -> IDLE on s_bvalid&&s_bready. RD_RESP -> IDLE on s_rvalid&&s_rready.
- In WR_REQ/RD_REQ:
  - bus_req = 1. bus_req_is_wr, bus_addr and bus_wr_data stay stable until bus_ready.
  - bus_wr_biten[8i+7:8i] = {8{wstrb[i]}}.
  - Reads drive bus_wr_data = 0 and bus_wr_biten = 0.
- On bus_ready:
  - Buffer entries are freed (AW+W, or AR).
  - For reads, s_rdata latches bus_rd_data.
  - resp = bus_err ? 2'b10 (SLVERR) : 2'b00 (OKAY).
- Timeout: a counter is cleared on entry to WR_REQ/RD_REQ and increments each cycle without bus_ready. When it reaches TIMEOUT_CYCLES, the bridge:
  - drops bus_req,
  - frees the buffers,
  - responds SLVERR, with s_rdata = 0 for reads.
- bus_req_stall_wr = (state == WR_RESP) && !s_bready. bus_req_stall_rd = (state == RD_RESP) && !s_rready.
- Addresses are passed unmodified, with no alignment check.

## Timing
- Reset values while rst = 0:
  - bus_req, bus_req_is_wr, s_bvalid, s_rvalid, both stall outputs = 0.
  - bus_addr, bus_wr_data, bus_wr_biten, s_rdata = 0. s_bresp, s_rresp = 2'b00.
  - s_awready, s_wready, s_arready = 1 (buffers empty).
  - FSM = IDLE; timeout counter = 0.
- Reset mid-transaction discards all buffered and in-flight state; no response is issued.
- Latency:
  - AW and W accepted in cycle N -> bus_req high in N+1.
  - bus_ready in cycle M -> s_bvalid/s_rvalid high in M+1.
  - Minimum AXI-accept to response is 2 cycles.
- AW and W may arrive in either order or together. A second AW is not accepted until the first write completes at the register bus.
- A read may be captured into the AR buffer while a write is in flight. It is served after the write's B handshake completes.
- s_bvalid/s_rvalid and their data/resp hold stable until the handshake completes. At most one of them is high at a time.
- bus_ready in the same cycle as the timeout expiry counts as success, not timeout.
- bus_ready seen outside WR_REQ/RD_REQ is ignored.

## Test plan
- Single write: AW 0x10, W 0xDEADBEEF, strb 4'b0101 in the same cycle -> bus_req in next cycle with is_wr=1, addr 0x10, biten 0x00FF00FF; bus_ready next -> s_bvalid with OKAY 1 cycle later.
- Single read: AR 0x24, bus_ready with rd_data 0xCAFE0001 -> s_rvalid, rdata 0xCAFE0001, rresp OKAY; hold s_rready=0 for 3 cycles -> rvalid and data stable, bus_req_stall_rd=1 for those cycles.
- W arrives 3 cycles before AW -> no bus_req until AW is captured; bus_err=1 on completion -> bresp 2'b10.
- Write and read eligible in the same cycle after reset -> write is served first, then the read. A subsequent tie is served read-first.
- TIMEOUT_CYCLES=4 with bus_ready held 0 -> bus_req stays high for 4 cycles, then drops; SLVERR response; the next transaction proceeds normally.
- Assert rst low while in WR_REQ -> all outputs return to reset values immediately; after release, s_bvalid never fires for the aborted write.
